// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter
//   Shares the single board indicator LED1 between four requesters. Each
//   requester asks for a blink code of 1..8 blinks; the block grants the LED
//   round-robin, plays the blink pattern on a prescaled OSC tick and pulses
//   DONE back to the served requester.
//
// Ports
//   OSC   in   system clock, all state on rising edge
//   RST   in   asynchronous active-high reset
//   REQ   in   [3:0]  request level per requester, sampled only in IDLE
//   CODE  in   [11:0] blink count CODE[3i+2:3i] for requester i (0 = 8)
//   GNT   out  [3:0]  one-hot grant, held for the whole service
//   DONE  out  [3:0]  one-cycle pulse to the served requester
//   BUSY  out         high while a grant is active
//   LED1  out         shared indicator
module led_blink_arbiter #(
  parameter int TICK_DIV  = 4,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 2,
  parameter int GAP_TICKS = 4
) (
  input  logic        OSC,
  input  logic        RST,
  input  logic [3:0]  REQ,
  input  logic [11:0] CODE,
  output logic [3:0]  GNT,
  output logic [3:0]  DONE,
  output logic        BUSY,
  output logic        LED1
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXA = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAXT = (MAXA > GAP_TICKS) ? MAXA : GAP_TICKS;
  localparam int HW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t          state;
  logic [PW-1:0]   pre;     // OSC prescaler
  logic [HW-1:0]   phase;   // ticks spent in current phase
  logic [3:0]      blinks;  // blinks still to play, including the current one
  logic [1:0]      ptr;     // last served requester
  logic            tick;

  // Per-requester blink count, CODE slice 0 meaning 8.
  logic [3:0][3:0] cnt_dec;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign cnt_dec[i] = (CODE[3*i +: 3] == 3'd0) ? 4'd8 : {1'b0, CODE[3*i +: 3]};
  end

  // Round-robin pick: walk from lowest priority (ptr itself) up to highest
  // (ptr+1) so the highest-priority requester overwrites the others.
  logic [1:0] pick;
  logic       pick_vld;
  always_comb begin
    logic [1:0] idx;
    pick     = ptr;
    pick_vld = 1'b0;
    idx      = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (REQ[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign tick = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge OSC or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      pre    <= '0;
      phase  <= '0;
      blinks <= '0;
      ptr    <= 2'd3;
      GNT    <= '0;
      DONE   <= '0;
      BUSY   <= 1'b0;
      LED1   <= 1'b0;
    end else begin
      DONE <= '0;
      // Phase ends always land on a tick, so the wrap keeps phases aligned.
      if (state != S_IDLE) pre <= tick ? '0 : pre + 1'b1;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            GNT    <= 4'b0001 << pick;
            BUSY   <= 1'b1;
            LED1   <= 1'b1;
            blinks <= cnt_dec[pick];
            ptr    <= pick;
            pre    <= '0;
            phase  <= '0;
            state  <= S_ON;
          end
        end
        S_ON: begin
          if (tick) begin
            if (phase == HW'(ON_TICKS - 1)) begin
              phase  <= '0;
              LED1   <= 1'b0;
              blinks <= blinks - 1'b1;
              // Last blink skips OFF and goes straight to the trailing gap.
              state  <= (blinks == 4'd1) ? S_GAP : S_OFF;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        S_OFF: begin
          if (tick) begin
            if (phase == HW'(OFF_TICKS - 1)) begin
              phase <= '0;
              LED1  <= 1'b1;
              state <= S_ON;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (phase == HW'(GAP_TICKS - 1)) begin
              phase <= '0;
              DONE  <= GNT;
              GNT   <= '0;
              BUSY  <= 1'b0;
              state <= S_IDLE;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// tb_led_blink_arbiter
//   Self-checking bench for led_blink_arbiter. A transaction-level reference
//   model turns each grant into the expected LED1 waveform (a queue of levels)
//   and predicts GNT/DONE/BUSY/LED1 every cycle; directed scenarios are
//   followed by a randomized REQ/CODE run.
module tb_led_blink_arbiter;

  localparam int TD  = 4;
  localparam int ON  = 2;
  localparam int OFF = 2;
  localparam int GAP = 4;

  logic        OSC = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  REQ = '0;
  logic [11:0] CODE = '0;
  logic [3:0]  GNT, DONE;
  logic        BUSY, LED1;

  led_blink_arbiter #(
    .TICK_DIV (TD),
    .ON_TICKS (ON),
    .OFF_TICKS(OFF),
    .GAP_TICKS(GAP)
  ) dut (
    .OSC (OSC),
    .RST (RST),
    .REQ (REQ),
    .CODE(CODE),
    .GNT (GNT),
    .DONE(DONE),
    .BUSY(BUSY),
    .LED1(LED1)
  );

  always #5 OSC = ~OSC;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model state
  logic m_busy = 1'b0;
  int   m_who  = 0;
  int   m_ptr  = 3;
  logic led_q[$];

  // Observation of the DUT for directed measurements
  int   gq[$];
  logic gnt_prev  = 1'b0;
  logic led_prev  = 1'b0;
  int   rise_cnt  = 0;
  int   gnt_cyc   = 0;
  int   done_cyc  = 0;
  logic done_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_ptr  = 3;
    led_q.delete();
    gnt_prev = 1'b0;
    led_prev = 1'b0;
  endtask

  // One clock: advance the model on the edge, then check outputs 1 time unit later.
  task automatic step();
    logic [3:0] e_gnt, e_done;
    logic       e_busy, e_led;
    int         w, n;
    @(posedge OSC);
    cyc++;
    e_done = '0;
    if (!m_busy) begin
      if (REQ != 4'h0) begin
        w = -1;
        for (int k = 1; k <= 4; k++) begin
          if (w < 0 && REQ[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        end
        m_ptr  = w;
        m_who  = w;
        m_busy = 1'b1;
        n = int'(CODE[3*w +: 3]);
        if (n == 0) n = 8;
        led_q.delete();
        for (int b = 0; b < n; b++) begin
          for (int c = 0; c < ON*TD; c++) led_q.push_back(1'b1);
          if (b < n - 1) for (int c = 0; c < OFF*TD; c++) led_q.push_back(1'b0);
        end
        for (int c = 0; c < GAP*TD; c++) led_q.push_back(1'b0);
      end
    end else if (led_q.size() == 0) begin
      e_done = 4'b0001 << m_who;
      m_busy = 1'b0;
    end
    if (m_busy) begin
      e_gnt  = 4'b0001 << m_who;
      e_busy = 1'b1;
      e_led  = led_q.pop_front();
    end else begin
      e_gnt  = '0;
      e_busy = 1'b0;
      e_led  = 1'b0;
    end
    #1;
    chk("gnt",  32'(GNT),  32'(e_gnt));
    chk("done", 32'(DONE), 32'(e_done));
    chk("busy", 32'(BUSY), 32'(e_busy));
    chk("led",  32'(LED1), 32'(e_led));
    if (GNT != 4'h0 && !gnt_prev) begin
      gq.push_back(onehot_idx(GNT));
      gnt_cyc = cyc;
    end
    if (DONE != 4'h0) begin
      done_cyc  = cyc;
      done_seen = 1'b1;
    end
    if (LED1 && !led_prev) rise_cnt++;
    gnt_prev = (GNT != 4'h0);
    led_prev = LED1;
  endtask

  // Steps until DONE is seen; an expired budget counts as a failure.
  task automatic run_until_done(input int maxc);
    int c = 0;
    done_seen = 1'b0;
    while (!done_seen && c < maxc) begin
      step();
      c++;
    end
    if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Called just after an edge: asserts reset, holds it across one edge.
  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    #1;
    chk("rst_gnt",  32'(GNT),  32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_led",  32'(LED1), 32'd0);
    @(posedge OSC);
    #1;
    chk("rst_hold_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
  endtask

  initial begin
    int c;
    #2;
    do_reset();

    // Idle with no requests
    for (int i = 0; i < 4; i++) step();

    // Single request, 3 blinks: 56 cycles grant to DONE
    REQ  = 4'b0001;
    CODE = 12'o0003;
    step();
    REQ = 4'b0000;
    rise_cnt = 1;
    run_until_done(100);
    chk("svc_len_3", 32'(done_cyc - gnt_cyc), 32'd56);
    chk("blinks_3",  32'(rise_cnt), 32'd3);
    step();

    // Code zero on requester 1: 8 blinks
    REQ  = 4'b0010;
    CODE = 12'o0000;
    rise_cnt = 0;
    run_until_done(200);
    chk("blinks_0", 32'(rise_cnt), 32'd8);
    REQ = 4'b0000;
    step();

    // Round-robin with all requesting from reset
    do_reset();
    REQ  = 4'b1111;
    CODE = 12'o1111;
    gq.delete();
    c = 0;
    while (gq.size() < 5 && c < 200) begin
      step();
      c++;
    end
    chk("rr_count", 32'(gq.size()), 32'd5);
    if (gq.size() >= 5) begin
      chk("rr0", 32'(gq[0]), 32'd0);
      chk("rr1", 32'(gq[1]), 32'd1);
      chk("rr2", 32'(gq[2]), 32'd2);
      chk("rr3", 32'(gq[3]), 32'd3);
      chk("rr4", 32'(gq[4]), 32'd0);
    end
    chk("rr_len", 32'(gnt_cyc - done_cyc), 32'd1);
    REQ = 4'b0000;
    run_until_done(50);
    step();

    // Priority rotation: serve 1, then 0 and 2 both ask -> 2 first
    do_reset();
    REQ = 4'b0010;
    step();
    REQ = 4'b0000;
    run_until_done(100);
    REQ = 4'b0101;
    gq.delete();
    step();
    step();
    chk("rot_first", (gq.size() > 0) ? 32'(gq[0]) : 32'hFFFF, 32'd2);
    REQ = 4'b0000;
    run_until_done(100);
    step();

    // Drop REQ during OFF and change CODE mid-service
    REQ  = 4'b0001;
    CODE = 12'o0002;
    step();
    rise_cnt = 1;
    for (int i = 0; i < 10; i++) step();
    REQ  = 4'b0000;
    CODE = 12'o7777;
    run_until_done(100);
    chk("drop_done", 32'(DONE), 32'b0001);
    chk("drop_blinks", 32'(rise_cnt), 32'd2);
    step();

    // Asynchronous reset in the middle of an ON phase
    REQ  = 4'b0100;
    CODE = 12'o0500;
    step();
    for (int i = 0; i < 3; i++) step();
    chk("pre_rst_led", 32'(LED1), 32'd1);
    REQ = 4'b0000;
    #2;
    do_reset();
    for (int i = 0; i < 5; i++) step();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0)
        REQ = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 1) == 1) CODE = 12'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
